// File: rtl/cle_pkg.sv
// Shared labeling-path package: image geometry and the pass-level FSM
// states. Used by the labeling engine and the bitmap packer.
package cle_pkg;

  localparam int IMG_W     = 32;
  localparam int IMG_PIX   = 1024;
  localparam int IMG_BYTES = 128;
  localparam int LBL_W     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } cle_state_e;

endpackage

// File: rtl/pack_shift8.sv
// 8-bit MSB-first shift register. The first bit shifted in ends up in
// bit 7 after eight shifts. q_next exposes the post-shift value so the
// caller can grab a completed byte in the same cycle as the last shift.
// inc pulses for every 1-bit shifted in, for a running popcount.
module pack_shift8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] q,
  output logic [7:0] q_next,
  output logic       inc
);

  assign q_next = {q[6:0], bit_in};
  assign inc    = shift_en & bit_in;

  // Shift state: cleared on reset or explicit clear, otherwise shifts in bit_in.
  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else if (shift_en)  q <= q_next;
  end

endmodule

// File: rtl/label_bitmap_packer.sv
// Re-packs a 32x32 8-bit label image from the label SRAM into the
// 128-byte binary bitmap format (pixel 0 of each byte in the MSB) and
// streams the bytes out over valid/ready, counting foreground pixels.
// Optional build macro LABEL_FILTER_EN adds sel_label: a nonzero value
// keeps only pixels carrying that label, so pix_cnt becomes its area.
module label_bitmap_packer #(
  parameter int NUM_BYTES = 128,
  parameter int SRAM_AW   = 10,
  parameter int LBL_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [SRAM_AW-1:0] sram_a,
  input  logic [LBL_W-1:0]   sram_q,
  output logic [7:0]         out_data,
  output logic [6:0]         out_addr,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef LABEL_FILTER_EN
  input  logic [LBL_W-1:0]   sel_label,
`endif
  output logic [10:0]        pix_cnt,
  output logic               busy,
  output logic               finish
);
  import cle_pkg::*;

  localparam logic [10:0] PIX_MAX  = 11'(NUM_BYTES * 8);
  localparam logic [6:0]  LAST_IDX = 7'(NUM_BYTES - 1);

  cle_state_e state, state_nx;
  logic [2:0] j;
  logic [6:0] byte_idx;
  logic       start_acc, hs, cap, bit_in, inc;
  logic [7:0] sr_q, sr_next;

  // A new pass can only be launched from an idle or finished FSM.
  assign start_acc = start && (state == IDLE || state == DONE);
  assign hs        = (state == EMIT) && out_ready;
  // SRAM data lags the address by one cycle: READ j>0 captures pixel j-1,
  // DRAIN captures pixel 7.
  assign cap       = ((state == READ) && (j != 3'd0)) || (state == DRAIN);

`ifdef LABEL_FILTER_EN
  logic [LBL_W-1:0] sel_q;
  assign bit_in = (sel_q != '0) ? (sram_q == sel_q) : (sram_q != '0);
`else
  assign bit_in = (sram_q != '0);
`endif

  pack_shift8 u_shift (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_acc),
    .shift_en (cap),
    .bit_in   (bit_in),
    .q        (sr_q),
    .q_next   (sr_next),
    .inc      (inc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: eight READ cycles, one DRAIN, then hold in EMIT until accepted.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = READ;
      READ:       if (j == 3'd7) state_nx = DRAIN;
      DRAIN:      state_nx = EMIT;
      EMIT:       if (out_ready) state_nx = (byte_idx == LAST_IDX) ? DONE : READ;
      default:    state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; the SRAM is only addressed during READ.
  always_comb begin
    sram_a    = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      READ:    begin sram_a = SRAM_AW'({byte_idx, j}); busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      EMIT:    begin busy = 1'b1; out_valid = 1'b1; end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pixel counter, byte index, popcount and output byte latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      j        <= '0;
      byte_idx <= '0;
      out_data <= '0;
      pix_cnt  <= '0;
`ifdef LABEL_FILTER_EN
      sel_q    <= '0;
`endif
    end else begin
      if (start_acc) begin
        j        <= '0;
        byte_idx <= '0;
        pix_cnt  <= '0;
`ifdef LABEL_FILTER_EN
        sel_q    <= sel_label;
`endif
      end
      if (state == READ) j <= j + 3'd1;
      if (inc && pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 11'd1;
      if (state == DRAIN) out_data <= sr_next;
      if (hs && byte_idx != LAST_IDX) byte_idx <= byte_idx + 7'd1;
    end
  end

  assign out_addr = byte_idx;

endmodule

// File: tb/tb_label_bitmap_packer.sv
// Directed bench for label_bitmap_packer: table of whole-image passes plus
// hand sequences for output stall and reset-abort behaviour.
module tb_label_bitmap_packer;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [9:0]  sram_a;
  logic [7:0]  sram_q, out_data;
  logic [6:0]  out_addr;
  logic        out_valid, busy, finish;
  logic [10:0] pix_cnt;
`ifdef LABEL_FILTER_EN
  logic [7:0]  sel_label;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [1024];
  logic [7:0] qd[$];
  int         qa[$];

  label_bitmap_packer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LABEL_FILTER_EN
    .sel_label (sel_label),
`endif
    .pix_cnt   (pix_cnt),
    .busy      (busy),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  // Synchronous-read label SRAM model.
  always @(posedge clk) sram_q <= mem[sram_a];

  // Record every byte that will be accepted at the coming edge.
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      qd.push_back(out_data);
      qa.push_back(int'(out_addr));
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string      name;
    int         pat;
    logic [7:0] sel;
    logic [7:0] b0, bmid, blast;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void fill(input int pat);
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        1:       mem[i] = 8'h00;
        2:       mem[i] = 8'($urandom_range(1, 255));
        3:       mem[i] = (i % 2 == 0) ? 8'h03 : 8'h00;
        4:       mem[i] = (i % 8 < 4) ? 8'h01 : 8'h02;
        default: mem[i] = 8'h00;
      endcase
    end
    if (pat == 1) begin
      mem[0] = 8'h05; mem[7] = 8'h05; mem[1023] = 8'h05;
    end
  endfunction

  function automatic int qbyte(input int i);
    return (i < qd.size()) ? int'(qd[i]) : -1;
  endfunction

  task automatic kick();
    qd.delete(); qa.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Launch a pass; report cycle (after start edge) of first out_valid and of finish.
  task automatic run_pass(output int lat_v, output int lat_f);
    lat_v = -1; lat_f = -1;
    kick();
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk); #1;
      if (out_valid && lat_v < 0) lat_v = k;
      if (finish) begin lat_f = k; break; end
    end
  endtask

  task automatic wait_finish(input string name);
    int ok = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      if (finish) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int lv, lf, errs, found;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
`ifdef LABEL_FILTER_EN
    sel_label = 8'h00;
`endif
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({sram_a, out_data, out_addr, out_valid, pix_cnt, busy, finish}), 0);
    reset = 1'b0;

    vecs.push_back('{"zero",  0, 8'h00, 8'h00, 8'h00, 8'h00, 0});
    vecs.push_back('{"three", 1, 8'h00, 8'h81, 8'h00, 8'h01, 3});
    vecs.push_back('{"full",  2, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1024});
    vecs.push_back('{"even",  3, 8'h00, 8'hAA, 8'hAA, 8'hAA, 512});
`ifdef LABEL_FILTER_EN
    vecs.push_back('{"filt2", 4, 8'h02, 8'h0F, 8'h0F, 8'h0F, 512});
    vecs.push_back('{"filt0", 4, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1024});
`endif

    foreach (vecs[v]) begin
      fill(vecs[v].pat);
`ifdef LABEL_FILTER_EN
      sel_label = vecs[v].sel;
`endif
      run_pass(lv, lf);
      chk({vecs[v].name, "_lat_valid"},  lv, 9);
      chk({vecs[v].name, "_lat_finish"}, lf, 1280);
      chk({vecs[v].name, "_nbytes"}, qd.size(), 128);
      errs = 0;
      foreach (qa[i]) if (qa[i] != i) errs++;
      chk({vecs[v].name, "_addr_order"}, errs, 0);
      chk({vecs[v].name, "_byte0"},   qbyte(0),   int'(vecs[v].b0));
      chk({vecs[v].name, "_byte127"}, qbyte(127), int'(vecs[v].blast));
      errs = 0;
      for (int i = 1; i < 127; i++) if (qbyte(i) != int'(vecs[v].bmid)) errs++;
      chk({vecs[v].name, "_mid_bytes"}, errs, 0);
      chk({vecs[v].name, "_pix_cnt"}, int'(pix_cnt), vecs[v].cnt);
      chk({vecs[v].name, "_busy_done"}, int'(busy), 0);
    end
`ifdef LABEL_FILTER_EN
    sel_label = 8'h00;
`endif

    // Output stall on byte 3: everything frozen, SRAM idle.
    fill(0); mem[24] = 8'h07;
    kick();
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_addr == 7'd3) begin found = 1; break; end
    end
    chk("stall_reach_byte3", found, 1);
    out_ready = 1'b0;
    errs = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!(out_valid && out_data == 8'h80 && out_addr == 7'd3 && sram_a == 10'd0 && busy)) errs++;
    end
    chk("stall_hold", errs, 0);
    chk("stall_accepted_before", qd.size(), 3);
    out_ready = 1'b1;
    wait_finish("stall_finish");
    chk("stall_nbytes", qd.size(), 128);
    chk("stall_byte3", qbyte(3), 8'h80);
    chk("stall_pix_cnt", int'(pix_cnt), 1);

    // Start while busy is ignored; reset during EMIT aborts the pass.
    fill(2);
    kick();
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (busy && sram_a[9:3] == 7'd10) begin found = 1; break; end
    end
    chk("abort_reach_byte10", found, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_addr == 7'd50) begin found = 1; break; end
    end
    chk("abort_reach_byte50", found, 1);
    chk("abort_pix_before", int'(pix_cnt), 51 * 8);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_reset_outputs", int'({sram_a, out_data, out_addr, out_valid, pix_cnt, busy, finish}), 0);
    reset = 1'b0;
    errs = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid || busy || finish) errs++;
    end
    chk("abort_quiet", errs, 0);
    chk("abort_nbytes", qd.size(), 50);
    errs = 0;
    foreach (qa[i]) if (qa[i] != i || qd[i] != 8'hFF) errs++;
    chk("abort_bytes_in_order", errs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
